// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Owns the PC, talks to instruction memory, and handles stall / redirect / halt drain.
module fetch_stage #(
  parameter int              PC_W      = 9,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              DRAIN_CYC = 3,
  parameter logic [31:0]     NOP       = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_valid,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            halt,
  output logic [PC_W-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic            id_valid,
  output logic            halted
);

  typedef enum logic [1:0] {FETCH, DRAIN, HALTED} state_t;

  localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYC - 1);

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [2:0]      drain_cnt;
  logic            halt_q;
  logic [PC_W-1:0] redir_tgt;

  // A halt decoded from a bubble is not a real instruction.
  assign halt_q    = halt && id_valid;
  assign redir_tgt = {redirect_pc[PC_W-1:2], 2'b00};
  assign imem_req  = (state == FETCH) && reset;
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      id_pc     <= '0;
      id_instr  <= NOP;
      id_valid  <= 1'b0;
      halted    <= 1'b0;
      drain_cnt <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (redirect) begin
            pc       <= redir_tgt;
            id_instr <= NOP;
            id_valid <= 1'b0;
          end else if (halt_q) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_INIT;
            id_instr  <= NOP;
            id_valid  <= 1'b0;
          end else if (stall) begin
            // Response dropped on purpose; the same word is refetched after the stall.
          end else if (imem_valid) begin
            id_pc    <= pc;
            id_instr <= imem_rdata;
            id_valid <= 1'b1;
            pc       <= pc + PC_W'(4);
          end else begin
            id_instr <= NOP;
            id_valid <= 1'b0;
          end
        end
        DRAIN: begin
          id_instr <= NOP;
          id_valid <= 1'b0;
          if (redirect) begin
            pc    <= redir_tgt;
            state <= FETCH;
          end else if (drain_cnt == '0) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
        end
        HALTED: begin
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: per-scenario vector tables fed through a scoreboard queue,
// each expected IF/ID / imem / halted snapshot checked one edge after it is driven.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        redirect;
  logic [8:0]  redirect_pc;
  logic        halt;
  logic [8:0]  id_pc;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        halted;

  int vecs = 0;
  int errs = 0;

  typedef struct {
    logic        st, iv, rd, hl;
    logic [8:0]  rpc;
    logic [8:0]  xpc;
    logic [31:0] xins;
    logic        xvld;
    logic [8:0]  xaddr;
    logic        xreq, xh;
  } vec_t;

  vec_t sb[$];

  fetch_stage #(.PC_W(9), .RESET_PC(9'h000), .DRAIN_CYC(3), .NOP(NOP)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .id_pc(id_pc), .id_instr(id_instr), .id_valid(id_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [8:0] a);
    return 32'hC0DE_0000 | {23'd0, a};
  endfunction

  function automatic vec_t mk(input logic st, iv, rd, hl, input logic [8:0] rpc,
                              input logic [8:0] xpc, input logic [31:0] xins,
                              input logic xvld, input logic [8:0] xaddr,
                              input logic xreq, xh);
    vec_t v;
    v.st = st; v.iv = iv; v.rd = rd; v.hl = hl; v.rpc = rpc;
    v.xpc = xpc; v.xins = xins; v.xvld = xvld; v.xaddr = xaddr;
    v.xreq = xreq; v.xh = xh;
    return v;
  endfunction

  // Fetch that lands word at address a and advances to a+4.
  function automatic vec_t fv(input logic [8:0] a);
    return mk(0, 1, 0, 0, 9'h0, a, mem(a), 1, a + 9'd4, 1, 0);
  endfunction

  task automatic drive(input vec_t v);
    stall = v.st; imem_valid = v.iv; redirect = v.rd; halt = v.hl;
    redirect_pc = v.rpc;
    imem_rdata = mem(imem_addr);
  endtask

  task automatic apply_reset();
    reset = 1'b0; stall = 0; imem_valid = 0; redirect = 0; halt = 0;
    redirect_pc = '0; imem_rdata = '0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1; imem_valid = 1; redirect = 1; halt = 1;
    redirect_pc = 9'h44; imem_rdata = 32'hDEAD_BEEF;
    #1;
    vecs++;
    if (imem_req !== 1'b0) begin
      errs++; $display("FAIL reset_req_low: got %b want 0", imem_req);
    end
    @(posedge clk); #1;
    vecs++;
    if ({id_pc, id_instr, id_valid, halted, imem_req, imem_addr} !== {9'h0, NOP, 1'b0, 1'b0, 1'b0, 9'h0}) begin
      errs++;
      $display("FAIL reset_state: got pc=%h ins=%h v=%b h=%b req=%b addr=%h want pc=0 ins=%h v=0 h=0 req=0 addr=0",
               id_pc, id_instr, id_valid, halted, imem_req, imem_addr, NOP);
    end
    stall = 0; redirect = 0; halt = 0; imem_valid = 0; reset = 1'b1;
    #1;
    vecs++;
    if ({imem_req, imem_addr} !== {1'b1, 9'h0}) begin
      errs++; $display("FAIL reset_release: got req=%b addr=%h want req=1 addr=0", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream();
    vec_t v[$];
    vec_t e;
    apply_reset();
    v.push_back(fv(9'h000)); v.push_back(fv(9'h004)); v.push_back(fv(9'h008));
    foreach (v[i]) begin
      drive(v[i]); sb.push_back(v[i]);
      @(posedge clk); #1; e = sb.pop_front(); vecs++;
      if ({id_valid, id_instr, imem_addr, imem_req, halted} !== {e.xvld, e.xins, e.xaddr, e.xreq, e.xh} || (e.xvld && id_pc !== e.xpc)) begin
        errs++;
        $display("FAIL stream[%0d]: got v=%b ins=%h pc=%h addr=%h req=%b h=%b want v=%b ins=%h pc=%h addr=%h req=%b h=%b",
                 i, id_valid, id_instr, id_pc, imem_addr, imem_req, halted, e.xvld, e.xins, e.xpc, e.xaddr, e.xreq, e.xh);
      end
    end
  endtask

  task automatic test_stall_bubble();
    vec_t v[$];
    vec_t e;
    apply_reset();
    v.push_back(fv(9'h000)); v.push_back(fv(9'h004));
    v.push_back(mk(1, 1, 0, 0, 9'h0, 9'h004, mem(9'h004), 1, 9'h008, 1, 0));
    v.push_back(mk(1, 1, 0, 0, 9'h0, 9'h004, mem(9'h004), 1, 9'h008, 1, 0));
    v.push_back(fv(9'h008));
    v.push_back(mk(0, 0, 0, 0, 9'h0, 9'h000, NOP, 0, 9'h00C, 1, 0));
    v.push_back(mk(0, 0, 0, 0, 9'h0, 9'h000, NOP, 0, 9'h00C, 1, 0));
    v.push_back(fv(9'h00C)); v.push_back(fv(9'h010));
    // halt takes priority over a simultaneous stall
    v.push_back(mk(1, 1, 0, 1, 9'h0, 9'h000, NOP, 0, 9'h014, 0, 0));
    foreach (v[i]) begin
      drive(v[i]); sb.push_back(v[i]);
      @(posedge clk); #1; e = sb.pop_front(); vecs++;
      if ({id_valid, id_instr, imem_addr, imem_req, halted} !== {e.xvld, e.xins, e.xaddr, e.xreq, e.xh} || (e.xvld && id_pc !== e.xpc)) begin
        errs++;
        $display("FAIL stall_bubble[%0d]: got v=%b ins=%h pc=%h addr=%h req=%b h=%b want v=%b ins=%h pc=%h addr=%h req=%b h=%b",
                 i, id_valid, id_instr, id_pc, imem_addr, imem_req, halted, e.xvld, e.xins, e.xpc, e.xaddr, e.xreq, e.xh);
      end
    end
  endtask

  task automatic test_redirect_wrap();
    vec_t v[$];
    vec_t e;
    apply_reset();
    for (int k = 0; k < 5; k++) v.push_back(fv(9'(4 * k)));
    v.push_back(mk(0, 1, 1, 0, 9'h041, 9'h000, NOP, 0, 9'h040, 1, 0));
    v.push_back(fv(9'h040));
    v.push_back(mk(0, 1, 1, 0, 9'h1FD, 9'h000, NOP, 0, 9'h1FC, 1, 0));
    v.push_back(mk(0, 1, 0, 0, 9'h0, 9'h1FC, mem(9'h1FC), 1, 9'h000, 1, 0));
    v.push_back(fv(9'h000));
    foreach (v[i]) begin
      drive(v[i]); sb.push_back(v[i]);
      @(posedge clk); #1; e = sb.pop_front(); vecs++;
      if ({id_valid, id_instr, imem_addr, imem_req, halted} !== {e.xvld, e.xins, e.xaddr, e.xreq, e.xh} || (e.xvld && id_pc !== e.xpc)) begin
        errs++;
        $display("FAIL redirect_wrap[%0d]: got v=%b ins=%h pc=%h addr=%h req=%b h=%b want v=%b ins=%h pc=%h addr=%h req=%b h=%b",
                 i, id_valid, id_instr, id_pc, imem_addr, imem_req, halted, e.xvld, e.xins, e.xpc, e.xaddr, e.xreq, e.xh);
      end
    end
  endtask

  task automatic test_halt();
    vec_t v[$];
    vec_t e;
    apply_reset();
    v.push_back(fv(9'h000));
    v.push_back(mk(0, 1, 0, 1, 9'h0, 9'h000, NOP, 0, 9'h004, 0, 0));
    v.push_back(mk(0, 1, 0, 0, 9'h0, 9'h000, NOP, 0, 9'h004, 0, 0));
    v.push_back(mk(0, 1, 0, 0, 9'h0, 9'h000, NOP, 0, 9'h004, 0, 0));
    v.push_back(mk(0, 1, 0, 0, 9'h0, 9'h000, NOP, 0, 9'h004, 0, 1));
    // once halted, redirects are ignored
    v.push_back(mk(0, 1, 1, 0, 9'h080, 9'h000, NOP, 0, 9'h004, 0, 1));
    v.push_back(mk(0, 1, 1, 0, 9'h080, 9'h000, NOP, 0, 9'h004, 0, 1));
    foreach (v[i]) begin
      drive(v[i]); sb.push_back(v[i]);
      @(posedge clk); #1; e = sb.pop_front(); vecs++;
      if ({id_valid, id_instr, imem_addr, imem_req, halted} !== {e.xvld, e.xins, e.xaddr, e.xreq, e.xh} || (e.xvld && id_pc !== e.xpc)) begin
        errs++;
        $display("FAIL halt[%0d]: got v=%b ins=%h pc=%h addr=%h req=%b h=%b want v=%b ins=%h pc=%h addr=%h req=%b h=%b",
                 i, id_valid, id_instr, id_pc, imem_addr, imem_req, halted, e.xvld, e.xins, e.xpc, e.xaddr, e.xreq, e.xh);
      end
    end
  endtask

  task automatic test_halt_redirect();
    vec_t v[$];
    vec_t e;
    apply_reset();
    v.push_back(fv(9'h000));
    v.push_back(mk(0, 1, 1, 1, 9'h080, 9'h000, NOP, 0, 9'h080, 1, 0));
    v.push_back(fv(9'h080)); v.push_back(fv(9'h084));
    // halt seen while IF/ID holds a bubble must be ignored
    v.push_back(mk(0, 0, 0, 0, 9'h0, 9'h000, NOP, 0, 9'h088, 1, 0));
    v.push_back(mk(0, 0, 0, 1, 9'h0, 9'h000, NOP, 0, 9'h088, 1, 0));
    v.push_back(fv(9'h088));
    // redirect in the middle of the drain
    v.push_back(mk(0, 1, 0, 1, 9'h0, 9'h000, NOP, 0, 9'h08C, 0, 0));
    v.push_back(mk(0, 1, 1, 0, 9'h100, 9'h000, NOP, 0, 9'h100, 1, 0));
    v.push_back(fv(9'h100)); v.push_back(fv(9'h104));
    v.push_back(fv(9'h108)); v.push_back(fv(9'h10C));
    foreach (v[i]) begin
      drive(v[i]); sb.push_back(v[i]);
      @(posedge clk); #1; e = sb.pop_front(); vecs++;
      if ({id_valid, id_instr, imem_addr, imem_req, halted} !== {e.xvld, e.xins, e.xaddr, e.xreq, e.xh} || (e.xvld && id_pc !== e.xpc)) begin
        errs++;
        $display("FAIL halt_redirect[%0d]: got v=%b ins=%h pc=%h addr=%h req=%b h=%b want v=%b ins=%h pc=%h addr=%h req=%b h=%b",
                 i, id_valid, id_instr, id_pc, imem_addr, imem_req, halted, e.xvld, e.xins, e.xpc, e.xaddr, e.xreq, e.xh);
      end
    end
  endtask

  task automatic test_reset_drain();
    vec_t v[$];
    vec_t e;
    apply_reset();
    v.push_back(fv(9'h000)); v.push_back(fv(9'h004));
    v.push_back(mk(0, 1, 0, 1, 9'h0, 9'h000, NOP, 0, 9'h008, 0, 0));
    v.push_back(mk(0, 1, 0, 0, 9'h0, 9'h000, NOP, 0, 9'h008, 0, 0));
    foreach (v[i]) begin
      drive(v[i]); sb.push_back(v[i]);
      @(posedge clk); #1; e = sb.pop_front(); vecs++;
      if ({id_valid, id_instr, imem_addr, imem_req, halted} !== {e.xvld, e.xins, e.xaddr, e.xreq, e.xh} || (e.xvld && id_pc !== e.xpc)) begin
        errs++;
        $display("FAIL reset_drain[%0d]: got v=%b ins=%h pc=%h addr=%h req=%b h=%b want v=%b ins=%h pc=%h addr=%h req=%b h=%b",
                 i, id_valid, id_instr, id_pc, imem_addr, imem_req, halted, e.xvld, e.xins, e.xpc, e.xaddr, e.xreq, e.xh);
      end
    end
    reset = 1'b0;
    @(posedge clk); #1;
    vecs++;
    if ({id_pc, id_instr, id_valid, halted, imem_req, imem_addr} !== {9'h0, NOP, 1'b0, 1'b0, 1'b0, 9'h0}) begin
      errs++;
      $display("FAIL reset_mid_drain: got pc=%h ins=%h v=%b h=%b req=%b addr=%h want pc=0 ins=%h v=0 h=0 req=0 addr=0",
               id_pc, id_instr, id_valid, halted, imem_req, imem_addr, NOP);
    end
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(fv(9'(4 * k))); sb.push_back(fv(9'(4 * k)));
      @(posedge clk); #1; e = sb.pop_front(); vecs++;
      if ({id_valid, id_instr, id_pc, imem_addr, imem_req, halted} !== {e.xvld, e.xins, e.xpc, e.xaddr, e.xreq, e.xh}) begin
        errs++;
        $display("FAIL after_reset[%0d]: got v=%b ins=%h pc=%h addr=%h req=%b h=%b want v=%b ins=%h pc=%h addr=%h req=%b h=%b",
                 k, id_valid, id_instr, id_pc, imem_addr, imem_req, halted, e.xvld, e.xins, e.xpc, e.xaddr, e.xreq, e.xh);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_bubble();
    test_redirect_wrap();
    test_halt();
    test_halt_redirect();
    test_reset_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vecs);
    $fatal(1, "timeout");
  end

endmodule
